// File: rtl/pito_mmio_uart.sv
// -----------------------------------------------------------------------------
// pito_mmio_uart
//   Memory-mapped 8N1 UART with TX/RX FIFOs on a simple req/we bus.
//
//   Register window (16 bytes at BASE_ADDR, addr[1:0] ignored):
//     0x0 DATA   : write pushes wdata[7:0] to TX FIFO (be[0]); read pops RX FIFO
//     0x4 STATUS : [0] tx_full [1] tx_empty [2] rx_valid [3] rx_overrun (W1C)
//                  [4] tx_busy [5] frame_err (W1C) [6] tx_drop (W1C)
//     0x8 DIV    : clk cycles per bit, [15:0], values below 4 clamp to 4
//     0xC CTRL   : [0] rx_ie [1] tx_ie (only with PITO_MMIO_UART_IRQ_EN)
//
//   Ports:
//     clk, rst           : clock, asynchronous active-high reset
//     req, we, addr,
//     wdata, be          : bus request, write enable, byte address, data, strobes
//     rdata, rvalid      : read data, valid the cycle after a read hit
//     tx, rx             : serial lines, idle high
//     irq                : registered level interrupt
//
//   Optional feature macro: PITO_MMIO_UART_IRQ_EN (interrupt enables + irq).
//   Without it CTRL reads 0, ignores writes and irq is constant 0.
// -----------------------------------------------------------------------------
module pito_mmio_uart #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] CLK_DIV_RST = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        tx,
  input  logic        rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- bus decode
  logic       bus_hit, bus_wr, bus_rd;
  logic [1:0] reg_sel;

  assign bus_hit = req && (addr[31:4] == BASE_ADDR[31:4]);
  assign bus_wr  = bus_hit && we;
  assign bus_rd  = bus_hit && !we;
  assign reg_sel = addr[3:2];

  // Bits of the bus that no register uses.
  logic unused_bus;
  assign unused_bus = ^{addr[1:0], be[3:1], wdata[31:16]};

  // ---------------------------------------------------------------- registers
  logic [15:0] div_reg;
  logic        ovr_reg, ferr_reg, drop_reg;
  logic [31:0] ctrl_rd;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr_reg, tx_rptr_reg;
  logic [CW-1:0] tx_count_reg;
  logic          tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_drop_set;
  logic [7:0]    tx_head;

  assign tx_full     = (tx_count_reg == FULL_CNT);
  assign tx_empty    = (tx_count_reg == '0);
  assign tx_push_req = bus_wr && (reg_sel == 2'd0) && be[0];
  // Fullness is judged before any pop in the same cycle.
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop_set = tx_push_req && tx_full;
  assign tx_head     = tx_mem[tx_rptr_reg];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_reg] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wptr_reg  <= '0;
      tx_rptr_reg  <= '0;
      tx_count_reg <= '0;
    end else begin
      if (tx_push) tx_wptr_reg <= tx_wptr_reg + 1'b1;
      if (tx_pop)  tx_rptr_reg <= tx_rptr_reg + 1'b1;
      tx_count_reg <= tx_count_reg + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wptr_reg, rx_rptr_reg;
  logic [CW-1:0] rx_count_reg;
  logic          rx_full, rx_valid, rx_push, rx_pop;
  logic [7:0]    rx_head;
  logic [7:0]    rx_shift_reg;

  assign rx_full  = (rx_count_reg == FULL_CNT);
  assign rx_valid = (rx_count_reg != '0);
  assign rx_pop   = bus_rd && (reg_sel == 2'd0) && rx_valid;
  assign rx_head  = rx_mem[rx_rptr_reg];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wptr_reg] <= rx_shift_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wptr_reg  <= '0;
      rx_rptr_reg  <= '0;
      rx_count_reg <= '0;
    end else begin
      if (rx_push) rx_wptr_reg <= rx_wptr_reg + 1'b1;
      if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + 1'b1;
      rx_count_reg <= rx_count_reg + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // ---------------------------------------------------------------- TX FSM
  tx_state_t   tx_state_reg, tx_state_next;
  logic [7:0]  tx_shift_reg;
  logic [15:0] tx_div_reg, tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic        tx_tick, tx_busy;

  assign tx_tick = (tx_cnt_reg == (tx_div_reg - 16'd1));
  assign tx_busy = (tx_state_reg != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state_reg <= TX_IDLE;
    else     tx_state_reg <= tx_state_next;
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_pop        = 1'b0;
    case (tx_state_reg)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_state_next = TX_START;
          tx_pop        = 1'b1;
        end
      end
      TX_START: if (tx_tick) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit_reg == 3'd7)) tx_state_next = TX_STOP;
      TX_STOP: begin
        if (tx_tick) begin
          // Chain straight into the next frame when more data is queued.
          if (!tx_empty) begin
            tx_state_next = TX_START;
            tx_pop        = 1'b1;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  // The divisor is captured on every frame start so DIV writes never
  // disturb a frame already on the wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_shift_reg <= '0;
      tx_div_reg   <= CLK_DIV_RST;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
    end else if (tx_pop) begin
      tx_shift_reg <= tx_head;
      tx_div_reg   <= div_reg;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
    end else if (tx_state_reg != TX_IDLE) begin
      if (tx_tick) begin
        tx_cnt_reg <= '0;
        if (tx_state_reg == TX_DATA) begin
          tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
          tx_bit_reg   <= tx_bit_reg + 1'b1;
        end
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end
    end
  end

  // Decoded from state only, so reset forces the line high at once.
  assign tx = (tx_state_reg == TX_START) ? 1'b0 :
              (tx_state_reg == TX_DATA)  ? tx_shift_reg[0] : 1'b1;

  // ---------------------------------------------------------------- RX FSM
  rx_state_t   rx_state_reg, rx_state_next;
  logic        rx_s1_reg, rx_s2_reg, rx_prev_reg;
  logic [15:0] rx_div_reg, rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic        rx_tick, rx_half_tick, rx_start, rx_ferr_set, rx_ovr_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_reg   <= 1'b1;
      rx_s2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_s1_reg   <= rx;
      rx_s2_reg   <= rx_s1_reg;
      rx_prev_reg <= rx_s2_reg;
    end
  end

  assign rx_tick      = (rx_cnt_reg == (rx_div_reg - 16'd1));
  assign rx_half_tick = (rx_cnt_reg == ((rx_div_reg >> 1) - 16'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state_reg <= RX_IDLE;
    else     rx_state_reg <= rx_state_next;
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_start      = 1'b0;
    rx_push       = 1'b0;
    rx_ferr_set   = 1'b0;
    rx_ovr_set    = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_s2_reg) begin
          rx_state_next = RX_START;
          rx_start      = 1'b1;
        end
      end
      // Mid start bit: a high line means it was only a glitch.
      RX_START: if (rx_half_tick) rx_state_next = rx_s2_reg ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit_reg == 3'd7)) rx_state_next = RX_STOP;
      // Mid stop bit: finish here so the next start edge is not missed.
      RX_STOP: begin
        if (rx_tick) begin
          rx_state_next = RX_IDLE;
          if (!rx_s2_reg)   rx_ferr_set = 1'b1;
          else if (rx_full) rx_ovr_set  = 1'b1;
          else              rx_push     = 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_div_reg   <= CLK_DIV_RST;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else if (rx_start) begin
      rx_div_reg <= div_reg;
      rx_cnt_reg <= '0;
      rx_bit_reg <= '0;
    end else begin
      case (rx_state_reg)
        RX_START: rx_cnt_reg <= rx_half_tick ? 16'd0 : rx_cnt_reg + 16'd1;
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_s2_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 1'b1;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + 16'd1;
          end
        end
        RX_STOP: rx_cnt_reg <= rx_cnt_reg + 16'd1;
        default: rx_cnt_reg <= rx_cnt_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------- DIV / sticky flags
  logic status_wr;
  assign status_wr = bus_wr && (reg_sel == 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg  <= CLK_DIV_RST;
      ovr_reg  <= 1'b0;
      ferr_reg <= 1'b0;
      drop_reg <= 1'b0;
    end else begin
      if (bus_wr && (reg_sel == 2'd2))
        div_reg <= (wdata[15:0] < 16'd4) ? 16'd4 : wdata[15:0];
      // A set in the same cycle as a W1C clear wins.
      ovr_reg  <= rx_ovr_set  || (ovr_reg  && !(status_wr && wdata[3]));
      ferr_reg <= rx_ferr_set || (ferr_reg && !(status_wr && wdata[5]));
      drop_reg <= tx_drop_set || (drop_reg && !(status_wr && wdata[6]));
    end
  end

  // ---------------------------------------------------------------- CTRL / irq
`ifdef PITO_MMIO_UART_IRQ_EN
  logic rx_ie_reg, tx_ie_reg, irq_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ie_reg <= 1'b0;
      tx_ie_reg <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      if (bus_wr && (reg_sel == 2'd3)) begin
        rx_ie_reg <= wdata[0];
        tx_ie_reg <= wdata[1];
      end
      irq_reg <= (rx_ie_reg && rx_valid) || (tx_ie_reg && tx_empty && !tx_busy);
    end
  end

  assign ctrl_rd = {30'd0, tx_ie_reg, rx_ie_reg};
  assign irq     = irq_reg;
`else
  assign ctrl_rd = '0;
  assign irq     = 1'b0;
`endif

  // ---------------------------------------------------------------- read path
  logic [6:0]  status_rd;
  logic [31:0] rd_mux;

  assign status_rd = {drop_reg, ferr_reg, tx_busy, ovr_reg, rx_valid, tx_empty, tx_full};

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      2'd0:    if (rx_valid) rd_mux = {24'd0, rx_head};
      2'd1:    rd_mux = {25'd0, status_rd};
      2'd2:    rd_mux = {16'd0, div_reg};
      default: rd_mux = ctrl_rd;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rdata  <= bus_rd ? rd_mux : 32'd0;
      rvalid <= bus_rd;
    end
  end

endmodule

// File: tb/tb_pito_mmio_uart.sv
// Self-checking bench for pito_mmio_uart with a queue-based reference model.
module tb_pito_mmio_uart;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic [31:0] rdata;
  logic        rvalid, tx, irq;
  logic        rx = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         m_tx_count;
  bit         m_tx_busy, m_ovr, m_ferr, m_drop;
  logic [7:0] m_rx_q[$];

  pito_mmio_uart #(
    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CLK_DIV_RST(16'd868)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .rdata(rdata), .rvalid(rvalid), .tx(tx), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] exp_status();
    return {25'd0, m_drop, m_ferr, m_tx_busy, m_ovr,
            m_rx_q.size() != 0, m_tx_count == 0, m_tx_count == DEPTH};
  endfunction

  task automatic model_reset();
    m_tx_count = 0; m_tx_busy = 0; m_ovr = 0; m_ferr = 0; m_drop = 0;
    m_rx_q.delete();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    $display("[TB] wr addr=%08h data=%08h be=%h", a, d, b);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = a;
    @(posedge clk); #1;
    d = rdata; v = rvalid;
    req = 1'b0;
    $display("[TB] rd addr=%08h data=%08h rvalid=%0b", a, d, v);
  endtask

  task automatic check_status(input string name);
    logic [31:0] d; logic v;
    bus_read(BASE + 32'h4, d, v);
    n_tests++;
    if ({v, d} !== {1'b1, exp_status()}) begin
      n_fail++;
      $display("FAIL %s: status got v=%0b %08h expected v=1 %08h", name, v, d, exp_status());
    end
  endtask

  // Drive one 8N1 frame; caller is aligned to a negedge afterwards.
  task automatic send_serial(input logic [7:0] b, input bit stop, input int div, input int gap);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (div) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    $display("[TB] rx frame byte=%02h stop=%0b div=%0d", b, stop, div);
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    logic [31:0] d; logic v;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({tx, rvalid, rdata, irq} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: tx=%0b rvalid=%0b rdata=%08h irq=%0b expected 1 0 0 0", tx, rvalid, rdata, irq);
    end
    model_reset();
    // First access accepted on the very first edge after release.
    @(negedge clk);
    rst = 1'b0; req = 1'b1; we = 1'b0; addr = BASE + 32'h4;
    @(posedge clk); #1;
    d = rdata; v = rvalid; req = 1'b0;
    n_tests++;
    if ({v, d} !== {1'b1, 32'h0000_0002}) begin
      n_fail++;
      $display("FAIL reset_first_access: got v=%0b %08h expected v=1 00000002", v, d);
    end
    bus_read(BASE + 32'h8, d, v);
    n_tests++;
    if (d !== 32'd868) begin
      n_fail++;
      $display("FAIL reset_div: got %08h expected %08h", d, 32'd868);
    end
    bus_read(BASE + 32'hC, d, v);
    n_tests++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %08h expected 00000000", d);
    end
  endtask

  task automatic test_div();
    logic [31:0] d, w; logic v;
    w = 32'($urandom_range(0, 3));
    bus_write(BASE + 32'h8, w, 4'hF);
    bus_read(BASE + 32'h8, d, v);
    n_tests++;
    if (d !== 32'd4) begin
      n_fail++;
      $display("FAIL div_clamp: wrote %0d got %08h expected 00000004", w, d);
    end
    w = 32'($urandom_range(4, 65535));
    bus_write(BASE + 32'h8, w, 4'hF);
    bus_read(BASE + 32'h8, d, v);
    n_tests++;
    if (d !== w) begin
      n_fail++;
      $display("FAIL div_rw: got %08h expected %08h", d, w);
    end
  endtask

  task automatic test_tx_frame();
    logic [7:0] b; logic [9:0] fb; logic [41:0] obs, expv;
    bus_write(BASE + 32'h8, 32'd4, 4'hF);
    for (int n = 0; n < 4; n++) begin
      b  = (n == 0) ? 8'h55 : 8'($urandom);
      fb = {1'b1, b, 1'b0};
      bus_write(BASE, {24'd0, b}, 4'h1);
      // Sample 0 is the idle cycle before the FSM leaves IDLE, 41 is after stop.
      for (int i = 0; i < 42; i++) begin
        @(negedge clk);
        obs[i]  = tx;
        expv[i] = (i == 0 || i == 41) ? 1'b1 : fb[(i - 1) / 4];
      end
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL tx_frame byte=%02h: got %011h expected %011h", b, obs, expv);
      end
    end
  endtask

  task automatic test_tx_busy();
    logic [31:0] d; logic v; logic [41:0] obs, expv;
    bus_write(BASE, {24'd0, 8'($urandom)}, 4'h1);
    // Read k reports the state after the previous edge; frame spans reads 2..41.
    for (int k = 1; k <= 42; k++) begin
      bus_read(BASE + 32'h4, d, v);
      obs[k-1]  = d[4];
      expv[k-1] = (k >= 2 && k <= 41);
    end
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL tx_busy: got %011h expected %011h", obs, expv);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b0, b1; logic [19:0] fb; logic [80:0] obs, expv;
    bus_write(BASE + 32'h8, 32'd4, 4'hF);
    b0 = 8'($urandom); b1 = 8'($urandom);
    fb = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    bus_write(BASE, {24'd0, b0}, 4'h1);
    bus_write(BASE, {24'd0, b1}, 4'h1);
    for (int i = 0; i < 81; i++) begin
      @(negedge clk);
      obs[i]  = tx;
      expv[i] = (i == 80) ? 1'b1 : fb[i / 4];
    end
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL tx_back_to_back %02h %02h: got %021h expected %021h", b0, b1, obs, expv);
    end
  endtask

  task automatic test_tx_fifo_full();
    bus_write(BASE + 32'h8, 32'h0000_FFFF, 4'hF);
    for (int i = 0; i < 10; i++) begin
      bus_write(BASE, {24'd0, 8'($urandom)}, 4'h1);
      // First byte goes straight into the shifter, the FIFO holds DEPTH more.
      if (i == 0)                m_tx_busy = 1;
      else if (m_tx_count < DEPTH) m_tx_count++;
      else                       m_drop = 1;
    end
    check_status("tx_full_drop");
    bus_write(BASE + 32'h4, 32'h40, 4'hF);
    m_drop = 0;
    check_status("tx_drop_w1c");
    // Abandon the frame with an asynchronous reset away from any clock edge.
    @(negedge clk); #2;
    n_tests++;
    if (tx !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_start_bit: got tx=%0b expected 0", tx);
    end
    rst = 1'b1; #1;
    n_tests++;
    if (tx !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got tx=%0b expected 1", tx);
    end
    model_reset();
    @(negedge clk); rst = 1'b0;
    check_status("after_reset");
  endtask

  task automatic test_bus_misc();
    logic [31:0] d; logic v;
    bus_write(BASE + 32'h10, 32'h5A, 4'h1);   // outside window
    bus_write(BASE, 32'hA5, 4'h0);            // byte lane 0 not enabled
    check_status("no_push");
    bus_read(BASE + 32'h14, d, v);
    n_tests++;
    if ({v, d} !== {1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL read_miss: got v=%0b %08h expected v=0 00000000", v, d);
    end
    bus_read(BASE + 32'h7, d, v);             // low address bits ignored
    n_tests++;
    if ({v, d} !== {1'b1, exp_status()}) begin
      n_fail++;
      $display("FAIL addr_low_bits: got v=%0b %08h expected v=1 %08h", v, d, exp_status());
    end
  endtask

  task automatic test_rx_bytes();
    logic [7:0] b; logic [31:0] d; logic v; int div;
    bus_write(BASE + 32'h8, 32'd8, 4'hF);
    for (int n = 0; n < 4; n++) begin
      b   = (n == 0) ? 8'hA3 : 8'($urandom);
      div = (n == 3) ? 13 : 8;
      if (n == 3) bus_write(BASE + 32'h8, div, 4'hF);
      send_serial(b, 1'b1, div, 3);
      m_rx_q.push_back(b);
      check_status("rx_valid");
      bus_read(BASE, d, v);
      n_tests++;
      if ({v, d} !== {1'b1, 24'd0, m_rx_q[0]}) begin
        n_fail++;
        $display("FAIL rx_data: got v=%0b %08h expected v=1 %08h", v, d, {24'd0, m_rx_q[0]});
      end
      void'(m_rx_q.pop_front());
      bus_read(BASE, d, v);
      n_tests++;
      if ({v, d} !== {1'b1, 32'd0}) begin
        n_fail++;
        $display("FAIL rx_empty_read: got v=%0b %08h expected v=1 00000000", v, d);
      end
      check_status("rx_drained");
    end
    bus_write(BASE + 32'h8, 32'd8, 4'hF);
  endtask

  task automatic test_rx_glitch_ferr();
    logic [7:0] b; logic [31:0] d; logic v;
    @(negedge clk); rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check_status("rx_glitch");
    send_serial(8'($urandom), 1'b0, 8, 4);
    m_ferr = 1;
    check_status("frame_err");
    bus_write(BASE + 32'h4, 32'h20, 4'hF);
    m_ferr = 0;
    check_status("frame_err_w1c");
    b = 8'($urandom);
    send_serial(b, 1'b1, 8, 3);
    bus_read(BASE, d, v);
    n_tests++;
    if ({v, d} !== {1'b1, 24'd0, b}) begin
      n_fail++;
      $display("FAIL rx_after_glitch: got v=%0b %08h expected v=1 %08h", v, d, {24'd0, b});
    end
  endtask

  task automatic test_rx_overrun();
    logic [7:0] b; logic [31:0] d; logic v;
    for (int i = 0; i < DEPTH + 1; i++) begin
      b = 8'($urandom);
      send_serial(b, 1'b1, 8, 0);             // frames sent with no idle gap
      if (m_rx_q.size() < DEPTH) m_rx_q.push_back(b);
      else                       m_ovr = 1;
    end
    repeat (4) @(negedge clk);
    check_status("rx_overrun");
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(BASE, d, v);
      n_tests++;
      if ({v, d} !== {1'b1, 24'd0, m_rx_q[0]}) begin
        n_fail++;
        $display("FAIL rx_fifo_order[%0d]: got v=%0b %08h expected v=1 %08h", i, v, d, {24'd0, m_rx_q[0]});
      end
      void'(m_rx_q.pop_front());
    end
    bus_write(BASE + 32'h4, 32'h08, 4'hF);
    m_ovr = 0;
    check_status("rx_overrun_w1c");
  endtask

  task automatic test_irq();
    logic [31:0] d; logic v;
`ifdef PITO_MMIO_UART_IRQ_EN
    bus_write(BASE + 32'hC, 32'h1, 4'hF);
    bus_read(BASE + 32'hC, d, v);
    n_tests++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL ctrl_rw: got %08h expected 00000001", d);
    end
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_idle: got %0b expected 0", irq);
    end
    send_serial(8'($urandom), 1'b1, 8, 3);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rx: got %0b expected 1", irq);
    end
    bus_read(BASE, d, v);
    repeat (2) @(negedge clk);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear_on_read: got %0b expected 0", irq);
    end
    bus_write(BASE + 32'hC, 32'h2, 4'hF);
    repeat (2) @(negedge clk);
    n_tests++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_tx_empty: got %0b expected 1", irq);
    end
    bus_write(BASE + 32'hC, 32'h0, 4'hF);
`else
    bus_write(BASE + 32'hC, 32'h3, 4'hF);
    bus_read(BASE + 32'hC, d, v);
    n_tests++;
    if ({v, d} !== {1'b1, 32'd0}) begin
      n_fail++;
      $display("FAIL ctrl_disabled: got v=%0b %08h expected v=1 00000000", v, d);
    end
    send_serial(8'($urandom), 1'b1, 8, 3);
    n_tests++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_disabled: got %0b expected 0", irq);
    end
    bus_read(BASE, d, v);
`endif
  endtask

  initial begin
    test_reset();
    test_div();
    test_tx_frame();
    test_tx_busy();
    test_back_to_back();
    test_bus_misc();
    test_rx_bytes();
    test_rx_glitch_ferr();
    test_rx_overrun();
    test_irq();
    test_tx_fifo_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pito_mmio_uart.md
PITO_MMIO_UART -- requirements
Module: pito_mmio_uart

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000: 16-byte-aligned base of register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO, power of 2, >=2.
REQ-003 SHALL have parameter CLK_DIV_RST, default 16'd868: reset value of baud divisor, in clk cycles per bit.
REQ-004 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have ports req, we  in  1 each: bus request and write enable.
REQ-007 SHALL have ports addr  in  32, wdata  in  32, be  in  4: byte address, write data, byte enables.
REQ-008 SHALL have ports rdata  out  32, rvalid  out  1: read data and its qualifier, one cycle after request.
REQ-009 SHALL have ports tx  out  1, rx  in  1: serial lines, 8N1, idle high.
REQ-010 SHALL have port irq  out  1: level interrupt, registered.

Function
REQ-011 Hit SHALL be req && addr[31:4]==BASE_ADDR[31:4]; addr[1:0] ignored; misses SHALL have no side effect and give rvalid=0.
REQ-012 Register map SHALL be: 0x0 DATA, 0x4 STATUS, 0x8 DIV, 0xC CTRL; undefined bits read 0.
REQ-013 Reads SHALL have latency 1: rvalid=1 and rdata valid in the cycle after a read hit; otherwise rvalid=0, rdata=0.
REQ-014 DATA write with be[0]=1 SHALL push wdata[7:0] into the TX FIFO; if full (sampled before any same-cycle pop), byte dropped and STATUS.tx_drop set.
REQ-015 DATA read SHALL pop the RX FIFO and return {24'b0, byte}; if empty, returns 0 with no pop.
REQ-016 STATUS SHALL be: [0] tx_full, [1] tx_empty, [2] rx_valid, [3] rx_overrun, [4] tx_busy, [5] frame_err, [6] tx_drop; bits 3, 5, 6 sticky, cleared by writing 1 (W1C); a same-cycle set wins over a clear.
REQ-017 DIV write SHALL load wdata[15:0]; values <4 clamp to 4; a new value takes effect at the next frame start for TX and the next start-bit detection for RX.
REQ-018 FIFOs SHALL accept simultaneous push and pop; pointers wrap modulo FIFO_DEPTH; occupancy counter is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-019 TX FSM SHALL have states IDLE, START, DATA, STOP; IDLE->START the cycle after the TX FIFO is non-empty (pop on that transition); each bit lasts exactly DIV cycles; data goes LSB first over 8 bits; STOP->START directly if FIFO non-empty (no idle gap), else ->IDLE.
REQ-020 tx_busy SHALL be 1 whenever the TX FSM is not in IDLE.
REQ-021 rx SHALL pass through a 2-flop synchronizer before use.
REQ-022 RX FSM SHALL have states IDLE, START, DATA, STOP; a falling edge in IDLE -> START; at DIV/2 cycles rx is resampled; if high, return to IDLE (glitch, no flags); else sample 8 bits at DIV intervals, then the stop bit.
REQ-023 Stop bit 0 SHALL set frame_err and discard the byte; stop bit 1 with RX FIFO full (sampled before any same-cycle pop) SHALL set rx_overrun and drop the byte; otherwise the byte is pushed.
REQ-024 RX SHALL return to IDLE at mid-stop-bit, so it can detect back-to-back frames.

Reset
REQ-025 On rst: tx=1, rdata=0, rvalid=0, irq=0, both FSMs IDLE, FIFOs empty, sticky bits 0, DIV=CLK_DIV_RST, CTRL=0; a frame in progress is abandoned immediately.
REQ-026 After rst deasserts, the first bus access SHALL be accepted in the same cycle.

Configuration
REQ-027 Macro PITO_MMIO_UART_IRQ_EN defined: CTRL[0]=rx_ie, CTRL[1]=tx_ie are read/write; irq is registered as (rx_ie && rx_valid) || (tx_ie && tx_empty && !tx_busy).
REQ-028 Macro PITO_MMIO_UART_IRQ_EN undefined: CTRL reads 0, writes are ignored, irq is tied to 0; all other behaviour is identical.

Verification
REQ-029 DIV=4; write DATA 0x55 -> tx shows start(0), 1,0,1,0,1,0,1,0, stop(1), 4 cycles per bit, 40 cycles total; tx_busy=1 throughout.
REQ-030 FIFO_DEPTH=8, tx stalled by DIV=0xFFFF; write 10 bytes -> the first is popped into the FSM and 8 are queued; tx_full=1; the 10th is dropped and tx_drop=1; W1C 0x40 clears tx_drop.
REQ-031 Drive 0xA3 serially at DIV=8 -> rx_valid=1; DATA read returns 0x000000A3 with rvalid one cycle later; a second read returns 0 and rx_valid=0.
REQ-032 Drive a frame with stop bit 0 -> frame_err=1 and FIFO stays empty; drive a 2-cycle low glitch at DIV=8 -> no flags, FSM back in IDLE.
REQ-033 Fill RX FIFO with 8 bytes, send a 9th -> rx_overrun=1 and the 8 stored bytes are read back in order.
REQ-034 With IRQ_EN: CTRL=1, receive a byte -> irq=1 the cycle after push; read DATA -> irq=0; assert rst mid-TX-frame -> tx=1 immediately.
